// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: master IDs, lock owner
// encoding, read-response tag and the default watchdog limit.
package ram_arbiter_pkg;

    localparam logic        MST_CORE     = 1'b0;
    localparam logic        MST_DBG      = 1'b1;
    localparam int unsigned LOCK_MAX_DEF = 64;
    localparam int unsigned RTAG_W       = 1;

    typedef enum logic [1:0] {
        LK_FREE = 2'd0,
        LK_CORE = 2'd1,
        LK_DBG  = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic              valid;
        logic [RTAG_W-1:0] mst;
    } rtag_t;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick with a per-master eligibility mask.
// The pointer flips to the other master after every grant and can be forced.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_ptr_set,
    input  logic       i_ptr_val,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic       r_ptr;
    logic [1:0] w_elig;

    always_comb begin
        w_elig = i_req & i_mask;
        if (w_elig == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end else begin
            o_gnt = w_elig;
        end
        o_gnt_idx = o_gnt[1];
    end

    // A grant always wins over a forced pointer value; both point away from the
    // same master whenever they coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= MST_CORE;
        end else if (|o_gnt) begin
            r_ptr <= ~o_gnt_idx;
        end else if (i_ptr_set) begin
            r_ptr <= i_ptr_val;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the core data port (m0) and the debug
// loader (m1): round-robin grant, bus lock for RMW, lock watchdog.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic                    m0_lock_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic                    m1_lock_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    ram_wvalid_o,
    output logic [ADDR_WIDTH-1:0]   ram_waddr_o,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [ADDR_WIDTH-1:0]   ram_raddr_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    lock_timeout_o
);

    localparam int unsigned WD_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    lock_state_e     r_lock;
    logic [WD_W-1:0] r_wd_cnt;
    rtag_t           r_rtag;

    logic       w_locked;
    logic       w_owner_idx;
    logic [1:0] w_mask;
    logic [1:0] w_gnt;
    logic       w_gidx;
    logic       w_acc;
    logic       w_we_sel;
    logic       w_lock_sel;
    logic       w_timeout;

    always_comb begin
        w_locked    = (r_lock != LK_FREE);
        w_owner_idx = (r_lock == LK_DBG);
        if (!w_locked) begin
            w_mask = 2'b11;
        end else begin
            w_mask = w_owner_idx ? 2'b10 : 2'b01;
        end
        w_timeout = (LOCK_MAX != 0) && w_locked
                    && (r_wd_cnt == WD_W'(LOCK_MAX - 1));
    end

    rr_arbiter2 u_rr (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_req     ({m1_req_i, m0_req_i}),
        .i_mask    (w_mask),
        .i_ptr_set (w_timeout),
        .i_ptr_val (~w_owner_idx),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gidx)
    );

    always_comb begin
        w_acc        = |w_gnt;
        w_we_sel     = w_gidx ? m1_we_i   : m0_we_i;
        w_lock_sel   = w_gidx ? m1_lock_i : m0_lock_i;
        ram_wvalid_o = w_acc & w_we_sel;
        ram_waddr_o  = '0;
        ram_raddr_o  = '0;
        ram_wstrb_o  = '0;
        ram_wdata_o  = '0;
        if (w_acc) begin
            ram_waddr_o = w_gidx ? m1_addr_i  : m0_addr_i;
            ram_raddr_o = w_gidx ? m1_addr_i  : m0_addr_i;
            ram_wstrb_o = w_gidx ? m1_wstrb_i : m0_wstrb_i;
            ram_wdata_o = w_gidx ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign m0_gnt_o       = w_gnt[0];
    assign m1_gnt_o       = w_gnt[1];
    assign lock_timeout_o = w_timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rtag <= '0;
        end else begin
            r_rtag.valid <= w_acc & ~w_we_sel;
            r_rtag.mst   <= w_gidx;
        end
    end

    assign m0_rvalid_o = r_rtag.valid & (r_rtag.mst == MST_CORE);
    assign m1_rvalid_o = r_rtag.valid & (r_rtag.mst == MST_DBG);
    assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

    // While locked only the owner can be accepted, so an accepted lock=0
    // transfer is either unlocked traffic or the owner's unlock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock   <= LK_FREE;
            r_wd_cnt <= '0;
        end else if (w_timeout) begin
            r_lock   <= LK_FREE;
            r_wd_cnt <= '0;
        end else if (w_acc) begin
            if (w_lock_sel) begin
                r_lock <= w_gidx ? LK_DBG : LK_CORE;
            end else begin
                r_lock <= LK_FREE;
            end
            r_wd_cnt <= '0;
        end else if (w_locked) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand sequences for lock,
// watchdog and reset, then random traffic against a behavioural model.
module tb_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LMAX = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_wvalid, lock_timeout;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [3:0]    ram_wstrb;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LMAX)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wstrb_i(m0_wstrb),
        .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
        .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wstrb_i(m1_wstrb),
        .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_wvalid_o(ram_wvalid), .ram_waddr_o(ram_waddr), .ram_wstrb_o(ram_wstrb),
        .ram_wdata_o(ram_wdata), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
        .lock_timeout_o(lock_timeout)
    );

    // Environment RAM: synchronous read, byte-enabled write.
    logic [DW-1:0] ram_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_raddr[AW-1:2]];
        if (ram_wvalid)
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) ram_mem[ram_waddr[AW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv0(input logic rq, input logic we, input logic [AW-1:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic lk);
        m0_req = rq; m0_we = we; m0_addr = a; m0_wstrb = s; m0_wdata = d; m0_lock = lk;
    endtask

    task automatic drv1(input logic rq, input logic we, input logic [AW-1:0] a,
                        input logic [3:0] s, input logic [31:0] d, input logic lk);
        m1_req = rq; m1_we = we; m1_addr = a; m1_wstrb = s; m1_wdata = d; m1_lock = lk;
    endtask

    task automatic idle();
        drv0(0, 0, '0, '0, '0, 0);
        drv1(0, 0, '0, '0, '0, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt0"}, 32'(m0_gnt), 0);
        chk({tag, " gnt1"}, 32'(m1_gnt), 0);
        chk({tag, " rvalid0"}, 32'(m0_rvalid), 0);
        chk({tag, " rvalid1"}, 32'(m1_rvalid), 0);
        chk({tag, " wvalid"}, 32'(ram_wvalid), 0);
        chk({tag, " timeout"}, 32'(lock_timeout), 0);
    endtask

    task automatic do_reset();
        tick(); rst_n = 0; idle();
        samp(); chk_quiet("reset");
        tick(); rst_n = 1;
    endtask

    typedef struct {
        logic [3:0]  stim;  // {req0, req1, we0, we1}
        logic [4:0]  expv;  // {gnt0, gnt1, rvalid0, rvalid1, wvalid}
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    // Reference model state
    int          p_prio, p_owner, p_cnt, p_pend;
    logic [31:0] p_pdata;
    logic [7:0]  mref [int];

    function automatic logic [31:0] ref_read(input int addr);
        logic [31:0] w;
        int base;
        base = addr & ~3;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = mref.exists(base + b) ? mref[base + b] : 8'h00;
        return w;
    endfunction

    initial begin
        vec_t vec [12];
        rst_n = 0; idle();
        repeat (2) @(posedge clk);
        samp(); chk_quiet("por");
        chk("por rdata0", m0_rdata, 0);
        tick(); rst_n = 1;

        // m0 write then read back
        tick(); drv0(1, 1, 14'h10, 4'hF, 32'hDEADBEEF, 0);
        samp();
        chk("t1 wr gnt0", 32'(m0_gnt), 1); chk("t1 wr gnt1", 32'(m1_gnt), 0);
        chk("t1 wvalid", 32'(ram_wvalid), 1); chk("t1 waddr", 32'(ram_waddr), 32'h10);
        chk("t1 wdata", ram_wdata, 32'hDEADBEEF); chk("t1 wstrb", 32'(ram_wstrb), 32'hF);
        tick(); drv0(1, 0, 14'h10, 4'h0, 32'h0, 0);
        samp();
        chk("t1 rd gnt0", 32'(m0_gnt), 1); chk("t1 rd wvalid", 32'(ram_wvalid), 0);
        chk("t1 raddr", 32'(ram_raddr), 32'h10); chk("t1 no wr resp", 32'(m0_rvalid), 0);
        tick(); idle();
        samp();
        chk("t1 rvalid0", 32'(m0_rvalid), 1); chk("t1 rdata0", m0_rdata, 32'hDEADBEEF);
        chk("t1 rvalid1", 32'(m1_rvalid), 0); chk("t1 rdata1", m1_rdata, 0);
        chk("t1 idle raddr", 32'(ram_raddr), 0);

        // byte-lane merge
        tick(); drv0(1, 1, 14'h30, 4'hF, 32'h11223344, 0);
        samp(); chk("t5 gnt a", 32'(m0_gnt), 1);
        tick(); drv0(1, 1, 14'h30, 4'b0010, 32'h0000AB00, 0);
        samp(); chk("t5 wstrb", 32'(ram_wstrb), 32'h2);
        tick(); drv0(1, 0, 14'h30, 4'h0, 32'h0, 0);
        samp();
        tick(); idle();
        samp();
        chk("t5 rvalid0", 32'(m0_rvalid), 1); chk("t5 rdata0", m0_rdata, 32'h1122AB44);

        // round-robin vector table from reset
        vec[0]  = '{4'b1100, 5'b10000, 32'h0, 32'h0};
        vec[1]  = '{4'b1100, 5'b01100, 32'hDEADBEEF, 32'h0};
        vec[2]  = '{4'b1100, 5'b10010, 32'h0, 32'h0};
        vec[3]  = '{4'b1100, 5'b01100, 32'hDEADBEEF, 32'h0};
        vec[4]  = '{4'b1100, 5'b10010, 32'h0, 32'h0};
        vec[5]  = '{4'b1100, 5'b01100, 32'hDEADBEEF, 32'h0};
        vec[6]  = '{4'b0100, 5'b01010, 32'h0, 32'h0};
        vec[7]  = '{4'b1100, 5'b10010, 32'h0, 32'h0};
        vec[8]  = '{4'b1110, 5'b01100, 32'hDEADBEEF, 32'h0};
        vec[9]  = '{4'b1010, 5'b10011, 32'h0, 32'h0};
        vec[10] = '{4'b0000, 5'b00000, 32'h0, 32'h0};
        vec[11] = '{4'b0101, 5'b01001, 32'h0, 32'h0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            drv0(vec[i].stim[3], vec[i].stim[1], 14'h10, 4'h0, 32'hA5A5A5A5, 0);
            drv1(vec[i].stim[2], vec[i].stim[0], 14'h14, 4'h0, 32'h5A5A5A5A, 0);
            samp();
            chk($sformatf("vec%0d gnt0", i), 32'(m0_gnt), 32'(vec[i].expv[4]));
            chk($sformatf("vec%0d gnt1", i), 32'(m1_gnt), 32'(vec[i].expv[3]));
            chk($sformatf("vec%0d rvalid0", i), 32'(m0_rvalid), 32'(vec[i].expv[2]));
            chk($sformatf("vec%0d rvalid1", i), 32'(m1_rvalid), 32'(vec[i].expv[1]));
            chk($sformatf("vec%0d wvalid", i), 32'(ram_wvalid), 32'(vec[i].expv[0]));
            chk($sformatf("vec%0d rdata0", i), m0_rdata, vec[i].rd0);
            chk($sformatf("vec%0d rdata1", i), m1_rdata, vec[i].rd1);
        end

        // m1 lock blocks m0 until unlock
        do_reset();
        tick(); drv0(1, 0, 14'h40, 4'h0, 32'h0, 0);
        samp(); chk("t3 pre gnt0", 32'(m0_gnt), 1);
        tick(); drv1(1, 0, 14'h20, 4'h0, 32'h0, 1);
        samp(); chk("t3 lock gnt1", 32'(m1_gnt), 1); chk("t3 lock gnt0", 32'(m0_gnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); drv1(0, 0, '0, '0, '0, 0);
            samp();
            chk($sformatf("t3 stall%0d gnt0", i), 32'(m0_gnt), 0);
            chk($sformatf("t3 stall%0d timeout", i), 32'(lock_timeout), 0);
        end
        tick(); drv1(1, 1, 14'h20, 4'hF, 32'h12345678, 0);
        samp();
        chk("t3 unlock gnt1", 32'(m1_gnt), 1); chk("t3 unlock gnt0", 32'(m0_gnt), 0);
        chk("t3 unlock wvalid", 32'(ram_wvalid), 1);
        tick(); drv1(0, 0, '0, '0, '0, 0);
        samp(); chk("t3 after gnt0", 32'(m0_gnt), 1);
        tick(); idle();

        // watchdog release
        do_reset();
        tick(); drv0(1, 0, 14'h44, 4'h0, 32'h0, 1);
        samp(); chk("t4 lock gnt0", 32'(m0_gnt), 1);
        for (int i = 1; i <= LMAX; i++) begin
            tick(); drv0(0, 0, '0, '0, '0, 0); drv1(1, 0, 14'h48, 4'h0, 32'h0, 0);
            samp();
            chk($sformatf("t4 c%0d gnt1", i), 32'(m1_gnt), 0);
            chk($sformatf("t4 c%0d timeout", i), 32'(lock_timeout), (i == LMAX) ? 1 : 0);
        end
        tick(); drv0(1, 0, 14'h4C, 4'h0, 32'h0, 0);
        samp();
        chk("t4 rel gnt1", 32'(m1_gnt), 1); chk("t4 rel gnt0", 32'(m0_gnt), 0);
        chk("t4 rel timeout", 32'(lock_timeout), 0);
        tick(); idle();

        // async reset after locked read: response dropped, lock cleared
        do_reset();
        tick(); drv0(1, 0, 14'h10, 4'h0, 32'h0, 1);
        samp(); chk("t6a gnt0", 32'(m0_gnt), 1);
        #1 rst_n = 0; idle();
        samp(); chk("t6a rvalid0 rst", 32'(m0_rvalid), 0); chk("t6a rdata0 rst", m0_rdata, 0);
        tick(); rst_n = 1;
        samp(); chk("t6a rvalid0 post", 32'(m0_rvalid), 0);
        tick(); drv1(1, 0, 14'h14, 4'h0, 32'h0, 0);
        samp(); chk("t6a owner clr gnt1", 32'(m1_gnt), 1);
        tick(); idle();
        tick(); drv0(1, 0, 14'h10, 4'h0, 32'h0, 0);
        samp(); chk("t6b gnt0", 32'(m0_gnt), 1);
        #1 rst_n = 0; idle();
        samp();
        tick(); rst_n = 1;
        drv0(1, 0, 14'h10, 4'h0, 32'h0, 0); drv1(1, 0, 14'h14, 4'h0, 32'h0, 0);
        samp();
        chk("t6b ptr gnt0", 32'(m0_gnt), 1); chk("t6b ptr gnt1", 32'(m1_gnt), 0);
        tick(); idle();

        // random traffic vs behavioural model
        do_reset();
        p_prio = 0; p_owner = -1; p_cnt = 0; p_pend = -1; p_pdata = '0;
        for (int n = 0; n < 2000; n++) begin
            logic        rq [2], wq [2], lk [2];
            logic [AW-1:0] ad [2];
            logic [3:0]  st [2];
            logic [31:0] wd [2];
            bit e0, e1, tmo;
            int g;
            for (int m = 0; m < 2; m++) begin
                rq[m] = ($urandom_range(0, 3) != 0);
                wq[m] = $urandom_range(0, 1) == 1;
                lk[m] = ($urandom_range(0, 3) == 0);
                ad[m] = AW'(32'h100 + $urandom_range(0, 63));
                st[m] = 4'($urandom_range(0, 15));
                wd[m] = $urandom;
            end
            tick();
            drv0(rq[0], wq[0], ad[0], st[0], wd[0], lk[0]);
            drv1(rq[1], wq[1], ad[1], st[1], wd[1], lk[1]);
            samp();
            e0 = rq[0] && (p_owner < 0 || p_owner == 0);
            e1 = rq[1] && (p_owner < 0 || p_owner == 1);
            g = -1;
            if (e0 && e1) g = p_prio; else if (e0) g = 0; else if (e1) g = 1;
            tmo = (p_owner >= 0) && (p_cnt == LMAX - 1);
            chk("rnd gnt0", 32'(m0_gnt), (g == 0) ? 1 : 0);
            chk("rnd gnt1", 32'(m1_gnt), (g == 1) ? 1 : 0);
            chk("rnd timeout", 32'(lock_timeout), tmo ? 1 : 0);
            chk("rnd wvalid", 32'(ram_wvalid), (g >= 0 && wq[g]) ? 1 : 0);
            chk("rnd raddr", 32'(ram_raddr), (g >= 0) ? 32'(ad[g]) : 0);
            chk("rnd waddr", 32'(ram_waddr), (g >= 0) ? 32'(ad[g]) : 0);
            chk("rnd wstrb", 32'(ram_wstrb), (g >= 0) ? 32'(st[g]) : 0);
            chk("rnd wdata", ram_wdata, (g >= 0) ? wd[g] : 0);
            chk("rnd rvalid0", 32'(m0_rvalid), (p_pend == 0) ? 1 : 0);
            chk("rnd rvalid1", 32'(m1_rvalid), (p_pend == 1) ? 1 : 0);
            chk("rnd rdata0", m0_rdata, (p_pend == 0) ? p_pdata : 0);
            chk("rnd rdata1", m1_rdata, (p_pend == 1) ? p_pdata : 0);
            // advance model across the coming clock edge
            if (g >= 0 && !wq[g]) begin
                p_pend = g; p_pdata = ref_read(int'(ad[g]));
            end else begin
                p_pend = -1;
            end
            if (g >= 0 && wq[g])
                for (int b = 0; b < 4; b++)
                    if (st[g][b]) mref[(int'(ad[g]) & ~3) + b] = wd[g][8*b +: 8];
            if (g >= 0) p_prio = 1 - g;
            if (tmo) begin
                p_prio = 1 - p_owner; p_owner = -1; p_cnt = 0;
            end else if (g >= 0) begin
                p_owner = lk[g] ? g : -1; p_cnt = 0;
            end else if (p_owner >= 0) begin
                p_cnt++;
            end
        end
        tick(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim time limit exceeded");
        $fatal(1, "time limit");
    end

endmodule
